// File: rtl/sec32_encoder.sv
`default_nettype none
// ============================================================================
// Module      : sec32_encoder
// Description : Two-stage elastic check-bit generator for the 32-bit SEC
//               code used by the c499 corrector. It also provides one-shot
//               single-bit error injection and a saturating count of
//               emitted words.
// Revision    : 1.0 - initial release
// ============================================================================
module sec32_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // upstream handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    // downstream handshake
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    // error injection
    input  logic             inj_arm,
    input  logic [5:0]       inj_bit,
    output logic             inj_pending,
    // statistics
    output logic [CNT_W-1:0] word_cnt
);

    // Index encoding of the injection target: below DATA_BITS flips a data
    // bit, below CODE_BITS flips a check bit, anything above is a no-op.
    localparam logic [5:0] DATA_BITS = 6'd32;
    localparam logic [5:0] CODE_BITS = 6'd40;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_data_q,  s1_data_d;
    logic [15:0]      s1_part_q,  s1_part_d;
    logic             s1_inj_q,   s1_inj_d;
    logic [5:0]       s1_idx_q,   s1_idx_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q,  s2_data_d;
    logic [7:0]       s2_check_q, s2_check_d;

    logic             inj_pending_q, inj_pending_d;
    logic [5:0]       inj_idx_q,     inj_idx_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;

    // Handshake wires
    logic             s2_ready;
    logic             in_fire;
    logic             s2_load;
    logic             out_fire;

    // Stage-1 partial parities
    logic [15:0]      part;
    // Stage-2 check bits before injection and the injection masks
    logic [7:0]       check_raw;
    logic [31:0]      flip_data;
    logic [7:0]       flip_check;

    // ------------------------------------------------------------------
    // Handshake: S2 frees up when empty or draining; S1 likewise against S2.
    // in_ready is therefore combinational from out_ready.
    // ------------------------------------------------------------------
    always_comb begin
        s2_ready = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_ready;
        in_fire  = in_valid && in_ready;
        s2_load  = s1_valid_q && s2_ready;
        out_fire = s2_valid_q && out_ready;
    end

    // Partial parities: part[0..7] are nibble parities, part[8..11] fold the
    // four low-half nibbles column-wise, part[12..15] the four high-half ones.
    always_comb begin
        part = '0;
        for (int n = 0; n < 8; n++) begin
            part[n] = ^in_data[4*n +: 4];
        end
        for (int j = 0; j < 4; j++) begin
            part[8 + j]  = in_data[j]      ^ in_data[j + 4]
                         ^ in_data[j + 8]  ^ in_data[j + 12];
            part[12 + j] = in_data[16 + j] ^ in_data[20 + j]
                         ^ in_data[24 + j] ^ in_data[28 + j];
        end
    end

    // Combine partials into check bits; each check covers one column group
    // plus two whole nibbles from the opposite half-word.
    always_comb begin
        check_raw[0] = s1_part_q[8]  ^ s1_part_q[4] ^ s1_part_q[5];
        check_raw[1] = s1_part_q[9]  ^ s1_part_q[6] ^ s1_part_q[7];
        check_raw[2] = s1_part_q[10] ^ s1_part_q[4] ^ s1_part_q[6];
        check_raw[3] = s1_part_q[11] ^ s1_part_q[5] ^ s1_part_q[7];
        check_raw[4] = s1_part_q[12] ^ s1_part_q[0] ^ s1_part_q[1];
        check_raw[5] = s1_part_q[13] ^ s1_part_q[2] ^ s1_part_q[3];
        check_raw[6] = s1_part_q[14] ^ s1_part_q[0] ^ s1_part_q[2];
        check_raw[7] = s1_part_q[15] ^ s1_part_q[1] ^ s1_part_q[3];
    end

    // Decode the tagged injection index into one-hot flip masks.
    always_comb begin
        flip_data  = '0;
        flip_check = '0;
        if (s1_inj_q) begin
            if (s1_idx_q < DATA_BITS) begin
                flip_data[s1_idx_q[4:0]] = 1'b1;
            end else if (s1_idx_q < CODE_BITS) begin
                flip_check[s1_idx_q[2:0]] = 1'b1;
            end
        end
    end

    // Next-state for both pipeline stages, the injection arm and the counter.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_data_d     = s1_data_q;
        s1_part_d     = s1_part_q;
        s1_inj_d      = s1_inj_q;
        s1_idx_d      = s1_idx_q;
        s2_valid_d    = s2_valid_q;
        s2_data_d     = s2_data_q;
        s2_check_d    = s2_check_q;
        inj_pending_d = inj_pending_q;
        inj_idx_d     = inj_idx_q;
        cnt_d         = cnt_q;

        // Stage 1: load wins over drain so a simultaneous move keeps it full.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_part_d  = part;
            // A same-cycle arm tags this word with the live index.
            s1_inj_d   = inj_arm || inj_pending_q;
            s1_idx_d   = inj_arm ? inj_bit : inj_idx_q;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_data_q ^ flip_data;
            s2_check_d = check_raw ^ flip_check;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        // Injection arm: the accepted word consumes the tag; a re-arm while
        // pending simply overwrites the index.
        if (inj_arm) begin
            inj_idx_d = inj_bit;
        end
        if (in_fire) begin
            inj_pending_d = 1'b0;
        end else if (inj_arm) begin
            inj_pending_d = 1'b1;
        end

        // Saturating emitted-word counter
        if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards in-flight words and any pending arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_part_q     <= '0;
            s1_inj_q      <= 1'b0;
            s1_idx_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_data_q     <= '0;
            s2_check_q    <= '0;
            inj_pending_q <= 1'b0;
            inj_idx_q     <= '0;
            cnt_q         <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_part_q     <= s1_part_d;
            s1_inj_q      <= s1_inj_d;
            s1_idx_q      <= s1_idx_d;
            s2_valid_q    <= s2_valid_d;
            s2_data_q     <= s2_data_d;
            s2_check_q    <= s2_check_d;
            inj_pending_q <= inj_pending_d;
            inj_idx_q     <= inj_idx_d;
            cnt_q         <= cnt_d;
        end
    end

    // Outputs come straight from the stage-2 and control registers.
    always_comb begin
        out_valid   = s2_valid_q;
        out_data    = s2_data_q;
        out_check   = s2_check_q;
        inj_pending = inj_pending_q;
        word_cnt    = cnt_q;
    end

endmodule
`default_nettype wire

// File: doc/sec32_encoder.md
# sec32_encoder

Streaming check-bit generator for the 32-bit single-error-correcting code consumed by the c499 corrector. Each accepted 32-bit data word produces the 8 check bits that give an all-zero corrector syndrome. The block is a two-stage elastic pipeline with valid/ready handshakes on both sides. It also provides one-shot single-bit error injection, so the corrector's correction path can be exercised end to end, and a saturating count of emitted words.

## Interface
- `CNT_W`, default 16: width of the emitted-word counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a word this cycle.
- `in_data` input 32: data word. Bit i corresponds to corrector data input N(4i+1).
- `out_valid` output 1: `out_data` and `out_check` are valid.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output 32: data part of the codeword, after any injection.
- `out_check` output 8: check bits. Bit k drives corrector input N(129+k).
- `inj_arm` input 1: pulse high to arm injection into the next accepted word.
- `inj_bit` input 6: codeword bit to flip. 0–31 select `out_data`, 32–39 select `out_check[bit-32]`, 40–63 inject nothing.
- `inj_pending` output 1: injection is armed and not yet consumed.
- `word_cnt` output `CNT_W`: number of words emitted; saturates at all ones.

## Operation
- Check equations, with d = `in_data`; each check bit is the XOR of 12 data bits:
  - c0 = d0^d4^d8^d12^d16^d17^d18^d19^d20^d21^d22^d23
  - c1 = d1^d5^d9^d13^d24^d25^d26^d27^d28^d29^d30^d31
  - c2 = d2^d6^d10^d14^d16^d17^d18^d19^d24^d25^d26^d27
  - c3 = d3^d7^d11^d15^d20^d21^d22^d23^d28^d29^d30^d31
  - c4 = d16^d20^d24^d28^d0^d1^d2^d3^d4^d5^d6^d7
  - c5 = d17^d21^d25^d29^d8^d9^d10^d11^d12^d13^d14^d15
  - c6 = d18^d22^d26^d30^d0^d1^d2^d3^d8^d9^d10^d11
  - c7 = d19^d23^d27^d31^d4^d5^d6^d7^d12^d13^d14^d15
- Stage 1 (S1) registers the data word, the 16 four-bit partial parities and an injection tag (flag plus 6-bit index).
- Stage 2 (S2) registers the final data and check bits with the injected flip applied. It feeds the outputs directly.
- Each stage has a valid bit.
  - A stage loads when its upstream is valid and it is empty or draining this cycle.
  - `in_ready` = !S1_valid | (!S2_valid | out_ready). This is combinational from `out_ready`.
- A transfer occurs when valid && ready on either side. Data is never dropped or duplicated, and order is preserved.
- Injection:
  - An `inj_arm` pulse latches `inj_bit` and sets `inj_pending`.
  - The next input transfer takes the tag and clears `inj_pending`.
  - If arm and transfer occur in the same cycle, that word is tagged with the current `inj_bit`.
  - Re-arming while pending overwrites the index.
- Counter: `word_cnt` increments on each output transfer and holds at 2^CNT_W−1.
- Outputs are held stable while out_valid && !out_ready.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_check`=0, `inj_pending`=0, `word_cnt`=0, both stage valids 0.
- `in_ready` is 1 in the first cycle after reset deassertion.
- Latency: a word accepted at edge t appears with `out_valid`=1 after edge t+2.
- Throughput: one word per cycle while `out_ready`=1.
- Full condition: both stages hold data and `out_ready`=0, so `in_ready`=0. When `out_ready` rises, one word moves per cycle with no bubble.
- Reset asserted mid-stream: all in-flight words and any pending injection are discarded immediately (asynchronous). The counter clears.

## Test plan
- Word 0x00000000, then 0x00000001, then 0xFFFFFFFF, then 0x00010000, with `out_ready`=1 -> `out_check` is 0x00, 0x51, 0x00, 0x15. Each appears 2 cycles after acceptance, back-to-back.
- Random 1000 words with random `out_ready` toggling -> output sequence equals input order. `out_check` matches the equations. Fed together into the c499 corrector with N137=1, the corrector outputs equal `out_data`.
- Hold `out_ready`=0 and offer 3 words -> the first 2 are accepted, then `in_ready`=0. Release -> 3 words emit in order on consecutive cycles.
- `inj_arm` with `inj_bit`=5 on word 0x12345678 -> `out_data`=0x12345658. The corrector restores 0x12345678. `inj_pending` is 1, then 0 after acceptance.
- `inj_bit`=33 on word 0x00000001 -> `out_check`=0x53, `out_data` unchanged. `inj_bit`=45 -> no flip.
- `CNT_W`=4 and 20 words emitted -> `word_cnt`=15. Reset pulsed mid-transfer -> all outputs 0 asynchronously.
